stopwatch_ctrl: RTL and testbench

Sequencing controller for the 4-digit BCD stopwatch datapath. It debounces the start/stop button, latches the counting mode, and issues load, enable and direction commands to the digit counters. Counter advances are gated by the divider's tick pulse, and the controller stops automatically at the terminal count. It sits between the push-button and `clk_div_disp` tick on one side and the counter/`hex2seg`/display chain on the other.

---
 rtl/stopwatch_pkg.sv | 29 ++
 rtl/stopwatch_ctrl_if.sv | 25 ++
 rtl/button_debounce.sv | 48 ++++
 rtl/stopwatch_ctrl.sv | 70 +++++++
 tb/tb_stopwatch_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: controller state encoding and counter load sources.
// The digit-counter datapath imports the same load_sel constants.
package stopwatch_pkg;

  localparam int unsigned MODE_W = 2;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_READY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [SEL_W-1:0] LD_ZERO   = 2'b00;
  localparam logic [SEL_W-1:0] LD_PRESET = 2'b01;
  localparam logic [SEL_W-1:0] LD_MAX    = 2'b10;

  // Start value for a mode: preset whenever mode[0] is set, else the direction's origin.
  function automatic logic [SEL_W-1:0] load_src(input logic [MODE_W-1:0] mode);
    case (mode)
      2'b00:   load_src = LD_ZERO;
      2'b10:   load_src = LD_MAX;
      default: load_src = LD_PRESET;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Controller <-> counter datapath signal bundle; master is the controller side.
interface stopwatch_ctrl_if import stopwatch_pkg::*; ();

  logic [MODE_W-1:0] mode;
  logic              tick;
  logic              at_max;
  logic              at_zero;
  logic              cnt_load;
  logic [SEL_W-1:0]  load_sel;
  logic              cnt_en;
  logic              cnt_up;
  logic              running;
  logic              done;

  modport master (
    input  mode, tick, at_max, at_zero,
    output cnt_load, load_sel, cnt_en, cnt_up, running, done
  );

  modport slave (
    output mode, tick, at_max, at_zero,
    input  cnt_load, load_sel, cnt_en, cnt_up, running, done
  );

endinterface

// File: rtl/button_debounce.sv
// Synchronizes and debounces a raw push-button; emits a one-cycle press on an accepted rising level.
module button_debounce #(
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic press
);

  localparam int unsigned      CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic [CNT_W-1:0]       cnt_q;
  logic                   stable_q;
  logic                   stable_d;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Level is accepted after DB_CYCLES consecutive cycles differing from the accepted level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      stable_d <= 1'b0;
      press    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_in};
      stable_d <= stable_q;
      press    <= stable_q & ~stable_d;
      if (sync_lvl != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          stable_q <= sync_lvl;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: button handling, mode latch, load/enable/direction commands.
module stopwatch_ctrl import stopwatch_pkg::*; #(
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startstop,
  stopwatch_ctrl_if.master  bus
);

  logic              press;
  state_t            state_q;
  logic [MODE_W-1:0] mode_q;
  logic              up;
  logic              term;
  logic              mode_chg;
  logic              in_init;

  button_debounce #(
    .DB_CYCLES   (DB_CYCLES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_button_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_in (startstop),
    .press  (press)
  );

  assign up       = ~mode_q[1];
  assign term     = up ? bus.at_max : bus.at_zero;
  assign mode_chg = (bus.mode != mode_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      mode_q  <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          mode_q  <= bus.mode;
          state_q <= ST_READY;
        end
        // A mode change outranks a simultaneous press while idle.
        ST_READY, ST_PAUSE: begin
          if (mode_chg)   state_q <= ST_INIT;
          else if (press) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (press)               state_q <= ST_PAUSE;
          else if (bus.tick && term) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (press || mode_chg) state_q <= ST_INIT;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Outputs decode the state register and are forced low for the whole reset cycle.
  assign in_init      = ~reset & (state_q == ST_INIT);
  assign bus.cnt_load = in_init;
  assign bus.load_sel = in_init ? load_src(bus.mode) : LD_ZERO;
  assign bus.cnt_en   = ~reset & (state_q == ST_RUN) & bus.tick & ~term & ~press;
  assign bus.cnt_up   = ~reset & up;
  assign bus.running  = ~reset & (state_q == ST_RUN);
  assign bus.done     = ~reset & (state_q == ST_DONE);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a behavioural model predicts every cycle's outputs.
module tb_stopwatch_ctrl;

  localparam int DB   = 4;
  localparam int SYNC = 2;

  localparam int PH_INIT  = 0;
  localparam int PH_READY = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_PAUSE = 3;
  localparam int PH_DONE  = 4;

  typedef struct {
    logic [6:0] o;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic startstop;

  logic       b_reset = 1'b1;
  logic       b_ss    = 1'b0;
  logic [1:0] b_mode  = 2'b01;
  logic       b_tick  = 1'b0;
  logic       b_max   = 1'b0;
  logic       b_zero  = 1'b0;

  stopwatch_ctrl_if bus ();

  assign reset       = b_reset;
  assign startstop   = b_ss;
  assign bus.mode    = b_mode;
  assign bus.tick    = b_tick;
  assign bus.at_max  = b_max;
  assign bus.at_zero = b_zero;

  stopwatch_ctrl #(
    .DB_CYCLES   (DB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .startstop (startstop),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         m_ph         = PH_INIT;
  logic [1:0] m_mode_q     = 2'b00;
  logic       m_stable     = 1'b0;
  logic       m_stable_old = 1'b0;
  logic       m_press      = 1'b0;
  logic       rawq[$]      = '{1'b0, 1'b0};
  logic       winq[$];

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;

  function automatic logic [1:0] sel_for(input logic [1:0] md);
    if (md[0]) return 2'd1;
    if (md[1]) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [6:0] model_out();
    logic term, load, en, up;
    logic [1:0] sel;
    if (b_reset) return 7'd0;
    up   = (m_mode_q[1] == 1'b0);
    term = up ? b_max : b_zero;
    load = (m_ph == PH_INIT);
    sel  = load ? sel_for(b_mode) : 2'd0;
    en   = (m_ph == PH_RUN) && b_tick && !term && !m_press;
    return {load, sel, en, up, 1'(m_ph == PH_RUN), 1'(m_ph == PH_DONE)};
  endfunction

  task automatic model_edge();
    logic term, sync, rise, all_diff;
    if (b_reset) begin
      m_ph = PH_INIT; m_mode_q = 2'b00;
      m_stable = 1'b0; m_stable_old = 1'b0; m_press = 1'b0;
      rawq = '{1'b0, 1'b0};
      winq.delete();
      return;
    end
    term = (m_mode_q[1] == 1'b0) ? b_max : b_zero;
    case (m_ph)
      PH_INIT: begin m_mode_q = b_mode; m_ph = PH_READY; end
      PH_READY, PH_PAUSE: begin
        if (b_mode != m_mode_q) m_ph = PH_INIT;
        else if (m_press)       m_ph = PH_RUN;
      end
      PH_RUN: begin
        if (m_press)              m_ph = PH_PAUSE;
        else if (b_tick && term)  m_ph = PH_DONE;
      end
      default: if (m_press || b_mode != m_mode_q) m_ph = PH_INIT;
    endcase
    // Button: accepted level flips once the last DB synchronized samples all disagree with it.
    sync = rawq[0];
    rise = m_stable && !m_stable_old;
    m_stable_old = m_stable;
    winq.push_back(sync);
    if (winq.size() > DB) void'(winq.pop_front());
    all_diff = (winq.size() == DB);
    foreach (winq[i]) if (winq[i] == m_stable) all_diff = 1'b0;
    if (all_diff) begin
      m_stable = ~m_stable;
      winq.delete();
    end
    m_press = rise;
    rawq.push_back(b_ss);
    void'(rawq.pop_front());
  endtask

  task automatic step();
    exp_t e;
    e.o   = model_out();
    e.cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic press_btn();
    b_ss = 1'b1; repeat (9) step();
    b_ss = 1'b0; repeat (9) step();
  endtask

  task automatic tick_every5(input int n, input int max_at, input int zero_at);
    for (int k = 0; k < n; k++) begin
      repeat (4) step();
      if (k == max_at)  b_max  = 1'b1;
      if (k == zero_at) b_zero = 1'b1;
      b_tick = 1'b1; step(); b_tick = 1'b0;
    end
  endtask

  task automatic press_with_tick();
    logic hit;
    b_ss = 1'b1;
    for (int i = 0; i < 20; i++) begin
      hit = m_press;
      b_tick = hit;
      step();
      b_tick = 1'b0;
      if (hit) break;
    end
    b_ss = 1'b0;
    repeat (9) step();
  endtask

  // Monitor: every cycle the DUT presents a command word; compare it with the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    logic [6:0] got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {bus.cnt_load, bus.load_sel, bus.cnt_en, bus.cnt_up, bus.running, bus.done};
      n_total++;
      if (got === e.o) n_pass++;
      else $display("FAIL outputs cyc=%0d {load,sel,en,up,run,done} got=%b exp=%b", e.cyc, got, e.o);
    end
  end

  initial begin
    int run_left;
    @(posedge clk); #1;
    repeat (3) step();
    b_reset = 1'b0;
    repeat (3) step();
    b_mode = 2'b00;
    repeat (3) step();

    repeat (2) begin
      b_ss = 1'b1; step(); step();
      b_ss = 1'b0; step(); step();
    end
    b_ss = 1'b1; repeat (10) step();
    b_ss = 1'b0; repeat (8) step();

    tick_every5(4, 2, -1);
    press_btn();
    b_max = 1'b0;
    repeat (2) step();

    press_btn();
    b_mode = 2'b10;
    repeat (3) step();
    press_with_tick();
    repeat (4) step();

    b_mode = 2'b11;
    repeat (3) step();
    press_btn();
    tick_every5(4, -1, 3);
    b_zero = 1'b0;
    press_btn();

    b_mode = 2'b01; b_max = 1'b1;
    repeat (3) step();
    press_btn();
    b_tick = 1'b1; step(); b_tick = 1'b0;
    repeat (2) step();
    b_max = 1'b0;
    press_btn();
    press_btn();
    tick_every5(2, -1, -1);
    b_reset = 1'b1; step();
    b_reset = 1'b0; repeat (4) step();

    run_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (run_left == 0) begin
        b_ss     = 1'($urandom_range(0, 1));
        run_left = int'($urandom_range(1, 12));
      end
      run_left--;
      b_tick  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) b_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) b_max  = ~b_max;
      if ($urandom_range(0, 15) == 0) b_zero = ~b_zero;
      b_reset = ($urandom_range(0, 299) == 0);
      step();
    end
    b_reset = 1'b0;
    @(negedge clk);
    #1;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain pending=%0d required=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
